ir_prefetch_queue: RTL and testbench

- Parametrised successor to the single-entry instruction register.
- Buffers up to DEPTH fetched instruction words in a FIFO ahead of a current-instruction register (IR).
- Splits the IR word into opcode (to the controller) and operand (driven to the W bus on request).
- Adds flush for jumps, a full flag and a sticky overflow flag.
- Sits between the W bus and the control sequencer.

---
 rtl/ir_prefetch_queue.sv | 63 ++++++
 tb/tb_ir_prefetch_queue.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: instruction prefetch FIFO feeding a current-instruction register with operand bus drive
module ir_prefetch_queue #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       li,
  input  logic [DATA_W-1:0]          bus_in,
  input  logic                       next,
  input  logic                       ei,
  output logic [DATA_W-1:0]          bus_out,
  output logic                       bus_oe,
  output logic [OPC_W-1:0]           opcode,
  output logic                       ir_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [DATA_W-1:0] ir;
  logic fill, pop, bypass, push, push_ok;
  // IR refill source selection and FIFO push acceptance; a pop frees a slot for a same-cycle push
  always_comb begin
    fill    = next | ~ir_valid;
    pop     = fill & (count != '0);
    bypass  = fill & (count == '0) & li;
    push    = li & ~bypass;
    push_ok = push & ((count < DEPTH_C) | pop);
  end
  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk)
    if (!reset && !flush && push_ok) mem[wr_ptr] <= bus_in;
  // pointers, occupancy, IR and sticky overflow; reset beats flush beats normal operation
  always_ff @(posedge clk)
    if (reset || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (fill) begin
        ir       <= pop ? mem[rd_ptr] : bypass ? bus_in : '0;
        ir_valid <= pop | bypass;
      end
      if (push && !push_ok) overflow <= 1'b1;
    end
  assign opcode  = ir[DATA_W-1 -: OPC_W];
  assign full    = count == DEPTH_C;
  assign bus_oe  = ei & ir_valid;
  assign bus_out = bus_oe ? {{OPC_W{1'b0}}, ir[DATA_W-OPC_W-1:0]} : '0;
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb_ir_prefetch_queue: directed scenario tests for the instruction prefetch queue
module tb_ir_prefetch_queue;
  logic clk = 0, reset = 1, flush = 0, li = 0, next = 0, ei = 0;
  logic [7:0] bus_in = '0;
  logic [7:0] bus_out;
  logic bus_oe, ir_valid, full, overflow;
  logic [3:0] opcode;
  logic [2:0] count;
  int n_cmp = 0, n_err = 0;

  ir_prefetch_queue #(.DATA_W(8), .OPC_W(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .li(li), .bus_in(bus_in), .next(next), .ei(ei),
    .bus_out(bus_out), .bus_oe(bus_oe), .opcode(opcode), .ir_valid(ir_valid),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] w);
    li = 1; bus_in = w; tick; li = 0;
  endtask

  task automatic test_reset;
    reset = 1; tick; reset = 0; ei = 1; #1;
    n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_ir_valid got %b exp 0", ir_valid); end
    n_cmp++; if (opcode !== 4'h0) begin n_err++; $display("FAIL reset_opcode got %h exp 0", opcode); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_cmp++; if ({full, overflow, bus_oe} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {full, overflow, bus_oe}); end
    n_cmp++; if (bus_out !== 8'h00) begin n_err++; $display("FAIL reset_bus_out got %h exp 00", bus_out); end
    ei = 0;
  endtask

  task automatic test_bypass;
    load(8'h3A);
    n_cmp++; if ({ir_valid, opcode} !== 5'h13) begin n_err++; $display("FAIL bypass_opcode got %h exp 13", {ir_valid, opcode}); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL bypass_count got %0d exp 0", count); end
    ei = 1; #1;
    n_cmp++; if ({bus_oe, bus_out} !== 9'h10A) begin n_err++; $display("FAIL operand got %h exp 10a", {bus_oe, bus_out}); end
    ei = 0; #1;
    n_cmp++; if ({bus_oe, bus_out} !== 9'h000) begin n_err++; $display("FAIL operand_off got %h exp 000", {bus_oe, bus_out}); end
  endtask

  task automatic test_fill_overflow;
    logic [3:0] exp_op [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    n_cmp++; if ({count, full, overflow} !== 5'b10010) begin n_err++; $display("FAIL fill_full got %b exp 10010", {count, full, overflow}); end
    load(8'h55);
    n_cmp++; if ({count, full, overflow} !== 5'b10011) begin n_err++; $display("FAIL overflow got %b exp 10011", {count, full, overflow}); end
    n_cmp++; if (opcode !== 4'h3) begin n_err++; $display("FAIL overflow_ir_kept got %h exp 3", opcode); end
    for (int i = 0; i < 4; i++) begin
      next = 1; tick; next = 0;
      n_cmp++; if (opcode !== exp_op[i]) begin n_err++; $display("FAIL drain_opcode_%0d got %h exp %h", i, opcode, exp_op[i]); end
      n_cmp++; if (count !== 3'(3 - i)) begin n_err++; $display("FAIL drain_count_%0d got %0d exp %0d", i, count, 3 - i); end
    end
  endtask

  task automatic test_full_push_pop;
    logic [3:0] exp_op [4] = '{4'hB, 4'hC, 4'hD, 4'h6};
    load(8'hA1); load(8'hB2); load(8'hC3); load(8'hD4);
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL refill_full got %b exp 1", full); end
    li = 1; next = 1; bus_in = 8'h66; tick; li = 0; next = 0;
    n_cmp++; if ({count, overflow, opcode} !== 8'b100_1_1010) begin n_err++; $display("FAIL full_push_pop got %b exp 10011010", {count, overflow, opcode}); end
    for (int i = 0; i < 4; i++) begin
      next = 1; tick; next = 0;
      n_cmp++; if (opcode !== exp_op[i]) begin n_err++; $display("FAIL order_opcode_%0d got %h exp %h", i, opcode, exp_op[i]); end
    end
    ei = 1; #1;
    n_cmp++; if (bus_out !== 8'h06) begin n_err++; $display("FAIL last_operand got %h exp 06", bus_out); end
    ei = 0;
  endtask

  task automatic test_flush;
    load(8'h12); load(8'h34);
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL preflush_count got %0d exp 2", count); end
    flush = 1; li = 1; next = 1; ei = 1; bus_in = 8'h77; tick;
    flush = 0; li = 0; next = 0; #1;
    n_cmp++; if ({count, ir_valid, opcode, overflow, bus_oe} !== 10'b0) begin n_err++; $display("FAIL flush_state got %b exp 0", {count, ir_valid, opcode, overflow, bus_oe}); end
    n_cmp++; if (bus_out !== 8'h00) begin n_err++; $display("FAIL flush_bus_out got %h exp 00", bus_out); end
    ei = 0;
  endtask

  task automatic test_drain_bypass;
    load(8'h5C);
    n_cmp++; if ({ir_valid, opcode} !== 5'h15) begin n_err++; $display("FAIL reload_opcode got %h exp 15", {ir_valid, opcode}); end
    next = 1; tick;
    n_cmp++; if ({ir_valid, opcode} !== 5'h00) begin n_err++; $display("FAIL empty_next got %h exp 00", {ir_valid, opcode}); end
    li = 1; bus_in = 8'hE7; tick; li = 0; next = 0;
    n_cmp++; if ({ir_valid, opcode, count} !== 8'b1_1110_000) begin n_err++; $display("FAIL next_bypass got %b exp 11110000", {ir_valid, opcode, count}); end
  endtask

  task automatic test_reset_mid;
    load(8'h01); load(8'h02); load(8'h03); load(8'h04); load(8'h05);
    next = 1; tick; next = 0;
    n_cmp++; if ({count, overflow, opcode} !== 8'b011_1_0000) begin n_err++; $display("FAIL pre_reset got %b exp 01110000", {count, overflow, opcode}); end
    reset = 1; ei = 1; tick; reset = 0; #1;
    n_cmp++; if ({count, overflow, full, ir_valid, opcode, bus_oe, bus_out} !== 19'b0) begin n_err++; $display("FAIL mid_reset got %b exp 0", {count, overflow, full, ir_valid, opcode, bus_oe, bus_out}); end
  endtask

  task automatic test_wrap;
    logic [7:0] q [$];
    logic [7:0] w, e;
    load(8'h10); load(8'h20); load(8'h31);
    q.push_back(8'h20); q.push_back(8'h31);
    for (int i = 0; i < 12; i++) begin
      w = 8'(8'h42 + i * 17);
      q.push_back(w);
      e = q.pop_front();
      li = 1; next = 1; bus_in = w; tick;
      n_cmp++; if ({opcode, bus_out[3:0], count} !== {e, 3'd2}) begin n_err++; $display("FAIL wrap_%0d got %h/%0d exp %h/2", i, {opcode, bus_out[3:0]}, count, e); end
    end
    li = 0; next = 0; ei = 0;
  endtask

  initial begin
    test_reset;
    test_bypass;
    test_fill_overflow;
    test_full_push_pop;
    test_flush;
    test_drain_bypass;
    test_reset_mid;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
